mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Load/store front-end between the CPU memory stage and the word-wide RAM.
//   Turns byte/halfword/word loads and stores at byte addresses into RAM word
//   operations. Sub-word loads are extracted and sign- or zero-extended.
//   The RAM has no byte enables, so sub-word stores run a read-modify-write
//   sequence. One request is handled at a time, with a busy/done handshake.
// PARAMETERS
//   ADDR_W  10  RAM word-address width (matches RAM addr[9:0])
//   RD_LAT  1   cycles from the ram_ld cycle to valid ram_dout (legal: 1..3)
// PORTS
//   clk       in   1         clock, rising edge
//   clr       in   1         async reset, active-low
//   req       in   1         request; sampled only in IDLE
//   we        in   1         1 = store, 0 = load
//   size      in   2         00 byte, 01 half, 10 word, 11 reserved
//   uns       in   1         load: 1 = zero-extend, 0 = sign-extend
//   addr      in   ADDR_W+2  byte address
//   wdata     in   32        store data, right-justified (byte in [7:0], half in [15:0])
//   rdata     out  32        load result, extended; held until the next accepted load
//   busy      out  1         state != IDLE
//   done      out  1         one-cycle pulse: request complete
//   misalign  out  1         one-cycle pulse with done: request rejected
//   ram_addr  out  ADDR_W    = latched addr[ADDR_W+1:2]
//   ram_din   out  32        write word
//   ram_sel   out  1         RAM select; high whenever ram_ld or ram_str is high
//   ram_ld    out  1         RAM read strobe
//   ram_str   out  1         RAM write strobe; RAM writes on the clk edge ending the cycle
//   ram_dout  in   32        RAM read data
// BEHAVIOUR
//   - Byte order is big-endian: byte offset 0 = bits [31:24]; half offset 0 = [31:16].
//   - Reset (clr=0, async): state IDLE. rdata, ram_addr, ram_din = 0.
//     busy, done, misalign, ram_sel, ram_ld, ram_str = 0.
//   - Accept rule: req=1 in IDLE at a clk edge latches we, size, uns, addr, wdata.
//     req while busy is ignored and not queued. The CPU re-issues after done.
//   - Alignment check at accept: half needs addr[0]=0; word needs addr[1:0]=00.
//     size=11 is always rejected. A rejected request goes IDLE->ERR.
//   - ERR state: done=1, misalign=1 for one cycle, then IDLE.
//     No RAM strobe is asserted and rdata is unchanged.
//   - States: IDLE, RD, WAIT, WR, DONE, ERR.
//     IDLE -> RD   on a load or sub-word store.
//     IDLE -> WR   on a word store.
//   - RD: one cycle, ram_sel=ram_ld=1.
//   - WAIT: RD_LAT cycles, counted by a 2-bit counter. ram_dout is captured
//     on the last edge. A load extracts and extends into rdata, then -> DONE.
//     A store merges the wdata lane into the captured word (other bytes kept)
//     into ram_din, then -> WR.
//   - WR: one cycle, ram_sel=ram_str=1, ram_din stable. Word stores use wdata
//     as-is. Then -> DONE.
//   - DONE: done=1 for one cycle, then IDLE. A new req in that IDLE cycle is
//     accepted, giving back-to-back throughput.
//   - Latency, counting the accept cycle as 0:
//       load: done in cycle 2+RD_LAT
//       word store: done in cycle 2
//       sub-word store: done in cycle 3+RD_LAT
//   - RAM strobes decode from registered state only (glitch-free).
//     ram_ld and ram_str are never high together.
//   - Reset mid-operation: all strobes drop immediately and the state goes to
//     IDLE with no done pulse. A RMW aborted before WR leaves memory unchanged.
// TESTING
//   1. RAM word 5 = 0x11223344. Load word at addr 0x014 -> rdata=0x11223344;
//      done in cycle 3 (RD_LAT=1).
//   2. RAM word 0 = 0x80FF7F00. Signed byte load at 0x000 -> 0xFFFFFF80.
//      Unsigned byte load at 0x001 -> 0x000000FF. Signed half load at 0x002
//      -> 0x00007F00.
//   3. RAM word 2 = 0xAABBCCDD. Byte store 0x55 at 0x00A -> one ram_ld, then
//      one ram_str with ram_din=0xAABB55DD; done in cycle 4.
//   4. Half load at 0x003 and word store at 0x006 -> misalign+done in cycle 1;
//      no ram_sel in either case; rdata unchanged.
//   5. Half store 0x1234 at 0x008. Pull clr low during WAIT -> no ram_str,
//      busy=0 at once, no done; a later load of word 2 returns the old value.
//   6. req held high continuously -> exactly one done per request. Requests
//      raised during busy are ignored. A req in the IDLE cycle after done is
//      accepted.

Source files
------------

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   Load/store front-end between the CPU memory stage and a word-wide RAM that
//   has no byte enables. Byte/halfword/word accesses at byte addresses become
//   RAM word operations:
//     - loads read one word and extract/extend the addressed lane into rdata,
//     - word stores write wdata straight through,
//     - sub-word stores read-modify-write (read word, merge lane, write word).
//   Byte order is big-endian: byte offset 0 lives in bits [31:24].
//   One request at a time; busy is high outside IDLE, done pulses on completion.
//
// Ports
//   clk       in   rising-edge clock
//   clr       in   asynchronous reset, active low
//   req       in   request, sampled only while idle
//   we        in   1 = store, 0 = load
//   size      in   00 byte, 01 half, 10 word, 11 reserved (always rejected)
//   uns       in   loads: 1 = zero-extend, 0 = sign-extend
//   addr      in   byte address (ADDR_W+2 bits)
//   wdata     in   store data, right-justified
//   rdata     out  extended load result, held until the next completed load
//   busy      out  high whenever a request is in flight
//   done      out  one-cycle completion pulse
//   misalign  out  one-cycle pulse together with done for a rejected request
//   ram_addr  out  RAM word address (latched addr[ADDR_W+1:2])
//   ram_din   out  RAM write word
//   ram_sel   out  RAM select, high with either strobe
//   ram_ld    out  RAM read strobe
//   ram_str   out  RAM write strobe (RAM writes on the edge ending the cycle)
//   ram_dout  in   RAM read data, valid RD_LAT cycles after the ram_ld cycle
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1    // legal range 1..3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W+1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_sel,
  output logic              ram_ld,
  output logic              ram_str,
  input  logic [31:0]       ram_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] CNT_LAST = 2'(RD_LAT - 1);

  state_t            state_reg, state_next;
  logic              we_reg;
  logic              uns_reg;
  logic [1:0]        size_reg;
  logic [ADDR_W+1:0] addr_reg;
  logic [15:0]       wdata_reg;   // sub-word stores never need more than 16 bits
  logic [1:0]        cnt_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       din_reg;

  logic              reject_in;
  logic [7:0]        lane_byte [4];
  logic [31:0]       merged;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_ext;

  // Reject check on the incoming request (evaluated in IDLE only).
  assign reject_in = (size == 2'b11) ||
                     ((size == SZ_HALF) && addr[0]) ||
                     ((size == SZ_WORD) && (addr[1:0] != 2'b00));

  // Per-lane view of the RAM word and per-lane merge for sub-word stores.
  // Lane gi occupies bits [31-8*gi -: 8] (big-endian lane order).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    logic lane_hit;

    assign lane_byte[gi] = ram_dout[31-8*gi -: 8];

    assign lane_hit = ((size_reg == SZ_BYTE) && (addr_reg[1:0] == LANE)) ||
                      ((size_reg == SZ_HALF) && (addr_reg[1] == LANE[1]));

    // A half places wdata[15:8] in the even lane and wdata[7:0] in the odd one.
    assign merged[31-8*gi -: 8] =
        !lane_hit                                   ? lane_byte[gi]    :
        ((size_reg == SZ_HALF) && (LANE[0] == 1'b0)) ? wdata_reg[15:8] :
                                                       wdata_reg[7:0];
  end

  assign byte_sel = lane_byte[addr_reg[1:0]];
  assign half_sel = {lane_byte[{addr_reg[1], 1'b0}], lane_byte[{addr_reg[1], 1'b1}]};

  always_comb begin
    load_ext = ram_dout;
    case (size_reg)
      SZ_BYTE: load_ext = {{24{~uns_reg & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_ext = {{16{~uns_reg & half_sel[15]}}, half_sel};
      default: load_ext = ram_dout;
    endcase
  end

  // Next-state logic and state-decoded outputs (strobes come from the state
  // register only, so they cannot glitch and drop as soon as clr asserts).
  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    done       = 1'b0;
    misalign   = 1'b0;
    ram_ld     = 1'b0;
    ram_str    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (req) begin
          if (reject_in)                   state_next = S_ERR;
          else if (we && (size == SZ_WORD)) state_next = S_WR;
          else                              state_next = S_RD;
        end
      end
      S_RD: begin
        ram_ld     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_reg == CNT_LAST) state_next = we_reg ? S_WR : S_DONE;
      end
      S_WR: begin
        ram_str    = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      S_ERR: begin
        done       = 1'b1;
        misalign   = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ram_sel  = ram_ld | ram_str;
  assign ram_addr = addr_reg[ADDR_W+1:2];
  assign ram_din  = din_reg;
  assign rdata    = rdata_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg <= S_IDLE;
      we_reg    <= 1'b0;
      uns_reg   <= 1'b0;
      size_reg  <= 2'b00;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cnt_reg   <= 2'b00;
      rdata_reg <= '0;
      din_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (req) begin
            we_reg    <= we;
            uns_reg   <= uns;
            size_reg  <= size;
            addr_reg  <= addr;
            wdata_reg <= wdata[15:0];
            // Word stores go straight to WR, so the write word is set up now.
            if (!reject_in && we && (size == SZ_WORD)) din_reg <= wdata;
          end
        end
        S_RD: cnt_reg <= 2'b00;
        S_WAIT: begin
          if (cnt_reg == CNT_LAST) begin
            if (we_reg) din_reg   <= merged;
            else        rdata_reg <= load_ext;
          end else begin
            cnt_reg <= cnt_reg + 2'b01;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a word RAM (one-cycle read) attached.
//   A request-level model predicts, cycle by cycle relative to each accepted
//   request, the handshake, strobes, RAM address/data and rdata; a compare
//   process checks the DUT against it every cycle. Directed tests add literal
//   expected values on top.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, misalign;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_sel, ram_ld, ram_str;
  logic [31:0] ram_dout = '0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.ADDR_W(10), .RD_LAT(1)) dut (
    .clk(clk), .clr(clr), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .misalign(misalign), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_sel(ram_sel), .ram_ld(ram_ld), .ram_str(ram_str), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM attached to the DUT: registered read, write on strobe.
  logic [31:0] ram_mem [0:1023];
  always @(posedge clk) begin
    if (ram_sel && ram_str) ram_mem[ram_addr] <= ram_din;
    if (ram_sel && ram_ld)  ram_dout <= ram_mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- request-level model ----------------
  logic [31:0] ref_mem [0:1023];

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic u, input logic [11:0] a);
    logic [31:0] v;
    int sh;
    if (sz == 2'b00) begin
      sh = 8 * (3 - int'(a[1:0]));
      v  = (w >> sh) & 32'h0000_00FF;
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'b01) begin
      sh = 16 * (1 - int'(a[1]));
      v  = (w >> sh) & 32'h0000_FFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [11:0] a);
    logic [31:0] m;
    int sh;
    if (sz == 2'b10) return wd;
    m  = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    sh = (sz == 2'b00) ? 8 * (3 - int'(a[1:0])) : 16 * (1 - int'(a[1]));
    return (w & ~(m << sh)) | ((wd & m) << sh);
  endfunction

  logic        m_active = 1'b0;
  int          m_cyc = 0;       // cycle index since accept (accept cycle = 0)
  int          m_lat = 0;       // cycle in which done is expected
  logic        m_err = 1'b0;
  logic        m_load = 1'b0;
  logic        m_rd = 1'b0;     // a RAM read is expected in cycle 1
  logic        m_st = 1'b0;     // a RAM write is expected in cycle m_lat-1
  logic [11:0] m_addr = '0;
  logic [31:0] m_new = '0;      // load result that appears with done
  logic [31:0] m_wword = '0;    // word the RAM must receive
  logic [31:0] m_rdata = '0;    // currently visible rdata

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_active = 1'b0;
      m_rdata  = '0;
    end else if (m_active) begin
      if (m_st && m_cyc == m_lat - 1) ref_mem[m_addr[11:2]] = m_wword;
      if (m_cyc == m_lat) begin
        if (m_load) m_rdata = m_new;
        m_active = 1'b0;
      end else begin
        m_cyc++;
      end
    end else if (req) begin
      m_active = 1'b1;
      m_cyc    = 1;
      m_addr   = addr;
      m_err    = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                 (size == 2'b10 && addr[1:0] != 2'b00);
      m_load   = !we && !m_err;
      m_st     = we && !m_err;
      m_rd     = !m_err && (!we || size != 2'b10);
      m_lat    = m_err ? 1 : (!we ? 3 : (size == 2'b10 ? 2 : 4));
      m_new    = model_load(ref_mem[addr[11:2]], size, uns, addr);
      m_wword  = model_merge(ref_mem[addr[11:2]], wdata, size, addr);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic e_done, e_ld, e_str;
    logic [31:0] e_rdata;
    e_done  = m_active && (m_cyc == m_lat);
    e_ld    = m_active && m_rd && (m_cyc == 1);
    e_str   = m_active && m_st && (m_cyc == m_lat - 1);
    e_rdata = (e_done && m_load) ? m_new : m_rdata;
    check("busy",     32'(busy),     32'(m_active));
    check("done",     32'(done),     32'(e_done));
    check("misalign", 32'(misalign), 32'(e_done && m_err));
    check("ram_ld",   32'(ram_ld),   32'(e_ld));
    check("ram_str",  32'(ram_str),  32'(e_str));
    check("ram_sel",  32'(ram_sel),  32'(e_ld || e_str));
    check("rdata",    rdata,         e_rdata);
    if (e_ld || e_str) check("ram_addr", 32'(ram_addr), 32'(m_addr[11:2]));
    if (e_str)         check("ram_din",  ram_din,       m_wword);
  end

  // ---------------- directed stimulus ----------------
  task automatic set_word(input int idx, input logic [31:0] v);
    ram_mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  // Issue one request and follow it to done. lat = cycle of done (accept = 0),
  // or -1 if done never came within the bound.
  task automatic run(input logic w, input logic [1:0] sz, input logic u,
                     input logic [11:0] a, input logic [31:0] d,
                     output int lat, output logic mis, output int selc,
                     output int ldc, output int stc, output logic [31:0] din);
    @(negedge clk);
    we = w; size = sz; uns = u; addr = a; wdata = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    lat = -1; mis = 1'b0; selc = 0; ldc = 0; stc = 0; din = '0;
    for (int n = 1; n <= 20; n++) begin
      if (ram_sel) selc++;
      if (ram_ld)  ldc++;
      if (ram_str) begin stc++; din = ram_din; end
      if (done) begin lat = n; mis = misalign; break; end
      @(negedge clk);
    end
    if (lat < 0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: no done for addr %h", a);
    end
  endtask

  initial begin
    int lat, selc, ldc, stc, ndone;
    logic mis;
    logic [31:0] din, r0;

    for (int i = 0; i < 1024; i++) set_word(i, 32'h0);
    set_word(5, 32'h1122_3344);
    set_word(0, 32'h80FF_7F00);
    set_word(2, 32'hAABB_CCDD);

    repeat (2) @(negedge clk);
    check("rst_rdata",    rdata,            32'h0);
    check("rst_ram_addr", 32'(ram_addr),    32'h0);
    check("rst_ram_din",  ram_din,          32'h0);
    check("rst_busy",     32'(busy),        32'h0);
    check("rst_sel",      32'(ram_sel),     32'h0);
    #1 clr = 1'b1;

    // 1: word load
    run(1'b0, 2'b10, 1'b0, 12'h014, 32'h0, lat, mis, selc, ldc, stc, din);
    check("t1_lat",   32'(lat), 32'd3);
    check("t1_rdata", rdata,    32'h1122_3344);

    // 2: sub-word loads
    run(1'b0, 2'b00, 1'b0, 12'h000, 32'h0, lat, mis, selc, ldc, stc, din);
    check("t2_sbyte", rdata, 32'hFFFF_FF80);
    run(1'b0, 2'b00, 1'b1, 12'h001, 32'h0, lat, mis, selc, ldc, stc, din);
    check("t2_ubyte", rdata, 32'h0000_00FF);
    run(1'b0, 2'b01, 1'b0, 12'h002, 32'h0, lat, mis, selc, ldc, stc, din);
    check("t2_shalf", rdata, 32'h0000_7F00);

    // 3: byte store read-modify-write
    run(1'b1, 2'b00, 1'b0, 12'h00A, 32'h0000_0055, lat, mis, selc, ldc, stc, din);
    check("t3_lat", 32'(lat), 32'd4);
    check("t3_ld",  32'(ldc), 32'd1);
    check("t3_str", 32'(stc), 32'd1);
    check("t3_din", din,      32'hAABB_55DD);

    // 4: misaligned requests
    r0 = rdata;
    run(1'b0, 2'b01, 1'b0, 12'h003, 32'h0, lat, mis, selc, ldc, stc, din);
    check("t4a_lat", 32'(lat),  32'd1);
    check("t4a_mis", 32'(mis),  32'd1);
    check("t4a_sel", 32'(selc), 32'd0);
    check("t4a_rd",  rdata,     r0);
    run(1'b1, 2'b10, 1'b0, 12'h006, 32'h1234_5678, lat, mis, selc, ldc, stc, din);
    check("t4b_lat", 32'(lat),  32'd1);
    check("t4b_mis", 32'(mis),  32'd1);
    check("t4b_sel", 32'(selc), 32'd0);
    check("t4b_rd",  rdata,     r0);
    run(1'b0, 2'b11, 1'b0, 12'h000, 32'h0, lat, mis, selc, ldc, stc, din);
    check("t4c_mis", 32'(mis),  32'd1);

    // 5: reset during WAIT of a half store
    @(negedge clk);
    we = 1'b1; size = 2'b01; uns = 1'b0; addr = 12'h008; wdata = 32'h0000_1234; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("t5_rd_strobe", 32'(ram_ld), 32'd1);
    @(posedge clk);
    #2 clr = 1'b0;
    #1;
    check("t5_busy", 32'(busy),    32'd0);
    check("t5_sel",  32'(ram_sel), 32'd0);
    check("t5_done", 32'(done),    32'd0);
    @(negedge clk);
    #1 clr = 1'b1;
    run(1'b0, 2'b10, 1'b0, 12'h008, 32'h0, lat, mis, selc, ldc, stc, din);
    check("t5_old", rdata, 32'hAABB_55DD);

    // extra patterns
    run(1'b0, 2'b01, 1'b0, 12'h016, 32'h0, lat, mis, selc, ldc, stc, din);
    check("x_half", rdata, 32'h0000_3344);
    run(1'b0, 2'b00, 1'b0, 12'h00B, 32'h0, lat, mis, selc, ldc, stc, din);
    check("x_sbyte", rdata, 32'hFFFF_FFDD);
    run(1'b1, 2'b10, 1'b0, 12'h01C, 32'hDEAD_BEEF, lat, mis, selc, ldc, stc, din);
    check("x_wst_lat", 32'(lat), 32'd2);
    check("x_wst_ld",  32'(ldc), 32'd0);
    run(1'b1, 2'b01, 1'b0, 12'h01E, 32'h0000_CAFE, lat, mis, selc, ldc, stc, din);
    check("x_hst_din", din, 32'hDEAD_CAFE);
    run(1'b0, 2'b10, 1'b0, 12'h01C, 32'h0, lat, mis, selc, ldc, stc, din);
    check("x_readback", rdata, 32'hDEAD_CAFE);

    // 6: req held high across several requests
    @(negedge clk);
    we = 1'b0; size = 2'b10; uns = 1'b0; addr = 12'h014; req = 1'b1;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    req = 1'b0;
    check("t6_dones", 32'(ndone), 32'd4);
    repeat (3) @(negedge clk);
    check("t6_idle",  32'(busy), 32'd0);
    check("t6_rdata", rdata,     32'h1122_3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
